// File: rtl/cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// cmd_dispatcher
//   UART command dispatcher. The first byte received while idle is matched
//   against a per-channel code table. On a match, that handler channel gets
//   its one-hot activate, and its TX requests are forwarded to the shared
//   uart_tx. On handler done, the block drains back to idle. An unmatched
//   command answers with NAK_BYTE.
//
//   Optional feature macro: DISPATCH_TIMEOUT_EN. When it is defined, a RUN
//   watchdog of TMO_CYC cycles is added.
//
// Ports
//   clk, reset     clock; asynchronous active-low reset
//   rx_ready       uart_rx byte-valid strobe
//   rx_data        uart_rx byte
//   tx_active      uart_tx busy
//   tx_data        registered byte to uart_tx
//   tx_start       registered uart_tx start pulse
//   ch_activate    one-hot handler enable (at most one bit high)
//   ch_done        per-channel completion (only the active channel is used)
//   ch_tx_data     per-channel TX byte, channel i at [i*DATA_W +: DATA_W]
//   ch_tx_start    per-channel TX start request
//   state_code     00 IDLE, 01 DRAIN, otherwise the latched command code
//   err_unknown    sticky: unmatched command seen
//   err_timeout    sticky: handler timed out (tied 0 without the macro)
//
// Handshake: rx_ready is a single-cycle valid strobe. There is no back-pressure
// on it. tx_start is a single-cycle request. For a NAK it is raised only when
// tx_active is low. Channel requests are forwarded as-is with one cycle of
// latency.
// -----------------------------------------------------------------------------
module cmd_dispatcher #(
  parameter int                       N_CH     = 4,
  parameter int                       DATA_W   = 8,
  parameter logic [N_CH*DATA_W-1:0]   CH_CODES = {8'h72, 8'h71, 8'h22, 8'h21},
  parameter logic [DATA_W-1:0]        NAK_BYTE = 8'h15,
  parameter logic [31:0]              TMO_CYC  = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_ready,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     tx_active,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  output logic [N_CH-1:0]          ch_activate,
  input  logic [N_CH-1:0]          ch_done,
  input  logic [N_CH*DATA_W-1:0]   ch_tx_data,
  input  logic [N_CH-1:0]          ch_tx_start,
  output logic [7:0]               state_code,
  output logic                     err_unknown,
  output logic                     err_timeout
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RUN, S_NAK, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cmd_q, cmd_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_CH-1:0]     act_q, act_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                err_unk_q, err_unk_d;
  logic                nak_sent_q, nak_sent_d;

  logic                match;
  logic [SEL_W-1:0]    match_idx;
  logic [7:0]          cmd_code;

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0]         timer_q, timer_d;
  logic                err_tmo_q, err_tmo_d;
`endif

  // Code match. Scanning from the top down lets the lowest index win.
  // Codes 00/01 are reserved for the display encoding and are never matched.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (CH_CODES[i*DATA_W +: DATA_W] == cmd_q &&
          CH_CODES[i*DATA_W +: DATA_W] > DATA_W'(1)) begin
        match     = 1'b1;
        match_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    act_d      = act_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_unk_d  = err_unk_q;
    nak_sent_d = nak_sent_q;
`ifdef DISPATCH_TIMEOUT_EN
    timer_d    = timer_q;
    err_tmo_d  = err_tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          cmd_d   = rx_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (match) begin
          sel_d            = match_idx;
          act_d            = '0;
          act_d[match_idx] = 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
          timer_d          = '0;
`endif
          state_d          = S_RUN;
        end else begin
          err_unk_d  = 1'b1;
          nak_sent_d = 1'b0;
          state_d    = S_NAK;
        end
      end
      S_RUN: begin
        tx_data_d  = ch_tx_data[sel_q*DATA_W +: DATA_W];
        tx_start_d = ch_tx_start[sel_q];
`ifdef DISPATCH_TIMEOUT_EN
        timer_d    = timer_q + 32'd1;
`endif
        if (ch_done[sel_q]) begin
          // A request arriving together with done is dropped, so tx_start
          // stays low once the FSM is in DRAIN.
          act_d      = '0;
          tx_start_d = 1'b0;
          state_d    = S_DRAIN;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (timer_q == TMO_CYC - 32'd1) begin
          act_d      = '0;
          tx_start_d = 1'b0;
          err_tmo_d  = 1'b1;
          nak_sent_d = 1'b0;
          state_d    = S_NAK;
        end
`endif
      end
      S_NAK: begin
        // Stay in NAK while the pulse is out. This keeps tx_start from being
        // seen high in DRAIN.
        if (nak_sent_q) begin
          state_d = S_DRAIN;
        end else if (!tx_active) begin
          tx_start_d = 1'b1;
          tx_data_d  = NAK_BYTE;
          nak_sent_d = 1'b1;
        end
      end
      S_DRAIN: begin
        act_d = '0;
        if (!rx_ready && !tx_active) state_d = S_IDLE;
      end
      default: begin
        act_d   = '0;
        state_d = S_DRAIN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_DRAIN;
      cmd_q      <= '0;
      sel_q      <= '0;
      act_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_unk_q  <= 1'b0;
      nak_sent_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      timer_q    <= '0;
      err_tmo_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      act_q      <= act_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_unk_q  <= err_unk_d;
      nak_sent_q <= nak_sent_d;
`ifdef DISPATCH_TIMEOUT_EN
      timer_q    <= timer_d;
      err_tmo_q  <= err_tmo_d;
`endif
    end
  end

  generate
    if (DATA_W >= 8) begin : g_code_wide
      assign cmd_code = cmd_q[7:0];
    end else begin : g_code_narrow
      assign cmd_code = {{(8-DATA_W){1'b0}}, cmd_q};
    end
  endgenerate

  // The display code is decoded from registered state only.
  always_comb begin
    case (state_q)
      S_IDLE:  state_code = 8'h00;
      S_DRAIN: state_code = 8'h01;
      default: state_code = cmd_code;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign ch_activate = act_q;
  assign err_unknown = err_unk_q;

`ifdef DISPATCH_TIMEOUT_EN
  assign err_timeout = err_tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TMO_CYC;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatcher
//   Self-checking bench for cmd_dispatcher. It uses 5 channels with a duplicate
//   code (0x21 on ch0 and ch3) and a reserved code (0x01 on ch4). It runs a
//   vector table, hand sequences (reset mid-RUN, done held through RUN entry,
//   timeout / no-timeout) and random commands. These are checked against a
//   code-table reference model and a TX byte scoreboard.
// -----------------------------------------------------------------------------
module tb_cmd_dispatcher;

  localparam int N_CH = 5;
  localparam logic [7:0] NAK = 8'h15;

  logic              clk;
  logic              reset;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              tx_active;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [N_CH-1:0]   ch_activate;
  logic [N_CH-1:0]   ch_done;
  logic [N_CH*8-1:0] ch_tx_data;
  logic [N_CH-1:0]   ch_tx_start;
  logic [7:0]        state_code;
  logic              err_unknown;
  logic              err_timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference code table, channel index order.
  logic [7:0] codes [N_CH] = '{8'h21, 8'h22, 8'h71, 8'h21, 8'h01};

  cmd_dispatcher #(
    .N_CH     (N_CH),
    .DATA_W   (8),
    .CH_CODES ({8'h01, 8'h21, 8'h71, 8'h22, 8'h21}),
    .NAK_BYTE (NAK),
    .TMO_CYC  (32'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_active   (tx_active),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ch_activate (ch_activate),
    .ch_done     (ch_done),
    .ch_tx_data  (ch_tx_data),
    .ch_tx_start (ch_tx_start),
    .state_code  (state_code),
    .err_unknown (err_unknown),
    .err_timeout (err_timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rx_ready    = 1'b0;
    rx_data     = 8'h00;
    tx_active   = 1'b0;
    ch_done     = '0;
    ch_tx_data  = '0;
    ch_tx_start = '0;
  endtask

  // Reference model: the lowest channel whose code equals the command wins.
  // Reserved codes 00/01 never match. The result is -1 for NAK.
  function automatic int ref_chan(input logic [7:0] cmd);
    for (int i = 0; i < N_CH; i++)
      if (codes[i] == cmd && codes[i] != 8'h00 && codes[i] != 8'h01) return i;
    return -1;
  endfunction

  // ---------------- scoreboard on TX bytes ----------------
  always @(negedge clk) begin
    if (reset && tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got tx_start data %0h expected no start", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for the queued NAK byte to be transmitted. Then check DRAIN -> IDLE.
  task automatic wait_nak();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("nak_sent", 32'(exp_q.size()), 0);
    check("nak_drain_code", state_code, 8'h01);
    check("nak_drain_act", ch_activate, 0);
    check("nak_drain_txs", tx_start, 0);
    step();
    check("nak_idle_code", state_code, 8'h00);
  endtask

  // Send one command with the DUT idle. Then act as the handler (or watch the NAK).
  task automatic do_cmd(input logic [7:0] cmd, input int exp_ch, input int n_tx, input bit noise);
    logic [N_CH-1:0] oh;
    logic [7:0] d;
    int j;
    int w;
    step();
    rx_ready = 1'b1;
    rx_data  = cmd;
    step();
    rx_ready = 1'b0;
    check("decode_code", state_code, {24'h0, cmd});
    check("decode_act", ch_activate, 0);
    check("decode_txs", tx_start, 0);
    step();
    if (exp_ch < 0) begin
      check("nak_err_unknown", err_unknown, 1);
      check("nak_act", ch_activate, 0);
      check("nak_code", state_code, {24'h0, cmd});
      exp_q.push_back(NAK);
      w = noise ? $urandom_range(1, 4) : 0;
      tx_active = (w != 0);
      for (int k = 0; k < w; k++) begin
        step();
        check("nak_wait_txs", tx_start, 0);
      end
      tx_active = 1'b0;
      wait_nak();
    end else begin
      oh = '0;
      oh[exp_ch] = 1'b1;
      check("run_act", ch_activate, 32'(oh));
      check("run_code", state_code, {24'h0, cmd});
      for (int k = 0; k < n_tx; k++) begin
        d = 8'($urandom);
        ch_tx_start[exp_ch] = 1'b1;
        ch_tx_data[exp_ch*8 +: 8] = d;
        exp_q.push_back(d);
        if (noise) begin
          j = (exp_ch + 1 + $urandom_range(0, N_CH - 2)) % N_CH;
          ch_tx_start[j] = 1'b1;
          ch_tx_data[j*8 +: 8] = 8'($urandom);
          ch_done[j] = 1'b1;
          rx_ready = 1'b1;
          rx_data = codes[$urandom_range(0, N_CH - 1)];
          tx_active = 1'($urandom_range(0, 1));
        end
        step();
        clear_inputs();
        check("run_hold_act", ch_activate, 32'(oh));
        if ($urandom_range(0, 1) == 1) begin
          step();
          check("run_gap_act", ch_activate, 32'(oh));
        end
      end
      ch_done[exp_ch] = 1'b1;
      step();
      ch_done = '0;
      check("done_act", ch_activate, 0);
      check("done_code", state_code, 8'h01);
      check("done_txs", tx_start, 0);
      check("done_sb_empty", 32'(exp_q.size()), 0);
      step();
      check("done_idle_code", state_code, 8'h00);
    end
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [7:0] cmd;
    int         exp_ch;
    int         n_tx;
    bit         noise;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [7:0] c;
    tbl[0] = '{8'h71, 2, 2, 1'b0};
    tbl[1] = '{8'h33, -1, 0, 1'b0};
    tbl[2] = '{8'h21, 0, 3, 1'b1};
    tbl[3] = '{8'h22, 1, 1, 1'b1};
    tbl[4] = '{8'h71, 2, 0, 1'b0};
    tbl[5] = '{8'h00, -1, 0, 1'b1};
    tbl[6] = '{8'h01, -1, 0, 1'b0};
    tbl[7] = '{8'h72, -1, 0, 1'b1};
    tbl[8] = '{8'hFF, -1, 0, 1'b0};

    clear_inputs();
    reset = 1'b0;
    repeat (3) step();
    check("rst_act", ch_activate, 0);
    check("rst_txs", tx_start, 0);
    check("rst_txd", tx_data, 0);
    check("rst_code", state_code, 8'h01);
    check("rst_err_unk", err_unknown, 0);
    check("rst_err_tmo", err_timeout, 0);
    reset = 1'b1;
    step();
    check("rst_to_idle", state_code, 8'h00);

    // Vector table
    for (int i = 0; i < 9; i++)
      do_cmd(tbl[i].cmd, tbl[i].exp_ch, tbl[i].n_tx, tbl[i].noise);

    // Done already high when RUN is entered: one RUN cycle, then DRAIN
    step();
    rx_ready = 1'b1;
    rx_data  = 8'h71;
    step();
    rx_ready = 1'b0;
    ch_done[2] = 1'b1;
    step();
    check("early_done_run", ch_activate, 32'h4);
    step();
    ch_done = '0;
    check("early_done_act", ch_activate, 0);
    check("early_done_code", state_code, 8'h01);
    step();
    check("early_done_idle", state_code, 8'h00);

    // Random commands checked against the reference model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) c = codes[$urandom_range(0, N_CH - 1)];
      else c = 8'($urandom_range(0, 255));
      do_cmd(c, ref_chan(c), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-RUN with ch1 active and a TX start pending
    check("sticky_err_unk", err_unknown, 1);
    step();
    rx_ready = 1'b1;
    rx_data  = 8'h22;
    step();
    rx_ready = 1'b0;
    step();
    check("t1_act", ch_activate, 32'h2);
    ch_tx_start[1] = 1'b1;
    ch_tx_data[15:8] = 8'h5A;
    step();
    ch_tx_start = '0;
    check("t1_txs_pre", tx_start, 1);
    reset = 1'b0;
    rx_ready = 1'b1;
    #1;
    check("t1_rst_act", ch_activate, 0);
    check("t1_rst_txs", tx_start, 0);
    check("t1_rst_code", state_code, 8'h01);
    check("t1_rst_err", err_unknown, 0);
    step();
    step();
    reset = 1'b1;
    step();
    check("t1_drain_rx", state_code, 8'h01);
    rx_ready = 1'b0;
    step();
    check("t1_idle", state_code, 8'h00);

    // Handler that never finishes
    step();
    rx_ready = 1'b1;
    rx_data  = 8'h21;
    step();
    rx_ready = 1'b0;
    step();
    check("t6_act", ch_activate, 32'h1);
`ifdef DISPATCH_TIMEOUT_EN
    repeat (99) step();
    check("t6_act_99", ch_activate, 32'h1);
    step();
    check("t6_tmo_act", ch_activate, 0);
    check("t6_tmo_err", err_timeout, 1);
    check("t6_tmo_code", state_code, 8'h21);
    exp_q.push_back(NAK);
    wait_nak();
`else
    repeat (999) step();
    check("t6_act_1000", ch_activate, 32'h1);
    check("t6_no_tmo", err_timeout, 0);
    ch_done[0] = 1'b1;
    step();
    ch_done = '0;
    check("t6_done_act", ch_activate, 0);
    step();
    check("t6_idle", state_code, 8'h00);
`endif

    repeat (2) step();
    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
